demux_lane_array: RTL

Parametrised successor to the two-lane 1:2 demux layer: LANES independent input lanes, each steered to one of FANOUT registered output slots. Adds a valid/ready handshake with per-slot backpressure, and a round-robin steering mode alongside the shared external selector. Sits between the lane-striping stage and the per-lane byte consumers, one clock domain.

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_lane.sv | 77 +++++++
 rtl/demux_lane_array.sv | 43 ++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared constants and slot indexing for the lane demux array.
package demux_pkg;

   localparam logic MODE_EXT = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   // Flat slot number of output k belonging to lane l.
   function automatic int slot_idx(input int lane, input int k, input int fanout);
      return lane * fanout + k;
   endfunction

endpackage

// File: rtl/demux_lane.sv
// One input lane steered into FANOUT registered one-entry slots, with a
// round-robin pointer and per-target ready.
module demux_lane
   import demux_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int FANOUT = 2,
   parameter int SELW   = $clog2(FANOUT)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mode,
   input  logic [SELW-1:0]         selector,
   input  logic [WIDTH-1:0]        data_in,
   input  logic                    valid_in,
   output logic                    ready_in,
   output logic [FANOUT*WIDTH-1:0] data_out,
   output logic [FANOUT-1:0]       valid_out,
   input  logic [FANOUT-1:0]       ready_out
);

   logic [SELW-1:0]               rr_ptr_r;
   logic [SELW-1:0]               target_s;
   logic [FANOUT-1:0]             valid_r;
   logic [FANOUT-1:0]             load_s;
   logic [FANOUT-1:0][WIDTH-1:0]  data_r;
   logic                          ready_s;
   logic                          accept_s;

   // Target selection and handshake; ready only looks at the targeted slot.
   always_comb begin
      if (mode == MODE_RR) begin
         target_s = rr_ptr_r;
      end else begin
         target_s = selector;
      end
      ready_s  = !valid_r[target_s] || ready_out[target_s];
      accept_s = valid_in && ready_s;
      load_s   = '0;
      if (accept_s) begin
         load_s[target_s] = 1'b1;
      end else begin
         load_s = '0;
      end
   end

   // Slot registers and round-robin pointer; a load wins over a drain so a
   // simultaneous drain+load keeps valid high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_r  <= '0;
         data_r   <= '0;
         rr_ptr_r <= '0;
      end else begin
         for (int k = 0; k < FANOUT; k++) begin
            if (load_s[k]) begin
               data_r[k]  <= data_in;
               valid_r[k] <= 1'b1;
            end else if (ready_out[k]) begin
               valid_r[k] <= 1'b0;
            end else begin
               valid_r[k] <= valid_r[k];
            end
         end
         if (accept_s && (mode == MODE_RR)) begin
            rr_ptr_r <= rr_ptr_r + SELW'(1);
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
      end
   end

   assign ready_in  = ready_s;
   assign valid_out = valid_r;
   assign data_out  = data_r;

endmodule

// File: rtl/demux_lane_array.sv
// LANES independent 1:FANOUT demux lanes; this level only slices the buses.
module demux_lane_array
   import demux_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int LANES  = 2,
   parameter int FANOUT = 2,
   parameter int SELW   = $clog2(FANOUT)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          mode,
   input  logic [SELW-1:0]               selector,
   input  logic [LANES*WIDTH-1:0]        data_in,
   input  logic [LANES-1:0]              valid_in,
   output logic [LANES-1:0]              ready_in,
   output logic [LANES*FANOUT*WIDTH-1:0] data_out,
   output logic [LANES*FANOUT-1:0]       valid_out,
   input  logic [LANES*FANOUT-1:0]       ready_out
);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam int BASE = slot_idx(l, 0, FANOUT);

      demux_lane #(
         .WIDTH  (WIDTH),
         .FANOUT (FANOUT),
         .SELW   (SELW)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .mode      (mode),
         .selector  (selector),
         .data_in   (data_in[l*WIDTH +: WIDTH]),
         .valid_in  (valid_in[l]),
         .ready_in  (ready_in[l]),
         .data_out  (data_out[BASE*WIDTH +: FANOUT*WIDTH]),
         .valid_out (valid_out[BASE +: FANOUT]),
         .ready_out (ready_out[BASE +: FANOUT])
      );
   end

endmodule
